// File: rtl/sha3_axil_slave.sv
// AXI4-Lite register front end for the SHA-3 core: CONTROL/STATUS/INPUT/COMMAND/OUTPUT map,
// INPUT words forwarded over valid/ready with the write response held until the core accepts.
module sha3_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 7,
    parameter int C_SHA3_SIZE        = 256
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            core_rst,
    output logic [31:0]                     core_in_data,
    output logic [1:0]                      core_in_bytes,
    output logic                            core_in_last,
    output logic                            core_in_valid,
    input  logic                            core_in_ready,
    input  logic                            core_out_valid,
    input  logic [C_SHA3_SIZE-1:0]          core_hash
);
    localparam int N_OUT = C_SHA3_SIZE / 32;
    localparam int WA    = C_S_AXI_ADDR_WIDTH - 2;

    typedef logic [WA-1:0] word_t;
    localparam word_t A_CTRL  = word_t'(0);
    localparam word_t A_STAT  = word_t'(1);
    localparam word_t A_IN    = word_t'(2);
    localparam word_t A_CMD   = word_t'(3);
    localparam word_t OUT_END = word_t'(4 + N_OUT);

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t     wstate, wstate_nx;
    rstate_t     rstate, rstate_nx;
    logic        awready_q, arready_q;
    word_t       waddr_q;
    logic [31:0] wdata_q;
    logic        wstrb0_q;
    logic [2:0]  ctrl_q;
    logic        done_q, sealed_q, core_rst_q;
    logic [1:0]  bresp_q, rresp_q;
    logic [31:0] rdata_q, rd_word;
    logic        rd_err, in_valid, wr_hs, rd_hs, cmd_go, w_err;
    word_t       rword;

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                           S_AXI_WSTRB[C_S_AXI_DATA_WIDTH/8-1:1]};

    assign wr_hs  = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_hs  = arready_q && S_AXI_ARVALID;
    assign cmd_go = (wstate == W_EXEC) && (waddr_q == A_CMD) && wdata_q[0];
    assign w_err  = (waddr_q >= OUT_END) || ((waddr_q == A_IN) && sealed_q);
    assign rword  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

    always_comb begin
        wstate_nx = wstate;
        in_valid  = 1'b0;
        case (wstate)
            W_IDLE: if (wr_hs) wstate_nx = W_EXEC;
            W_EXEC: begin
                if ((waddr_q == A_IN) && !sealed_q) begin
                    in_valid = 1'b1;
                    if (core_in_ready) wstate_nx = W_RESP;
                end else begin
                    wstate_nx = W_RESP;
                end
            end
            W_RESP: if (S_AXI_BREADY) wstate_nx = W_IDLE;
            default: wstate_nx = W_IDLE;
        endcase
    end

    // A COMMAND clear takes priority over a completion landing in the same cycle.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            wstate     <= W_IDLE;
            awready_q  <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            wstrb0_q   <= 1'b0;
            ctrl_q     <= '0;
            done_q     <= 1'b0;
            sealed_q   <= 1'b0;
            bresp_q    <= '0;
            core_rst_q <= 1'b0;
        end else begin
            wstate     <= wstate_nx;
            awready_q  <= (wstate == W_IDLE) && S_AXI_AWVALID && S_AXI_WVALID && !awready_q;
            core_rst_q <= cmd_go;
            if (wr_hs) begin
                waddr_q  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                wdata_q  <= S_AXI_WDATA[31:0];
                wstrb0_q <= S_AXI_WSTRB[0];
            end
            if ((wstate == W_EXEC) && (waddr_q == A_CTRL) && wstrb0_q)
                ctrl_q <= wdata_q[2:0];
            if (cmd_go)              done_q <= 1'b0;
            else if (core_out_valid) done_q <= 1'b1;
            if (cmd_go)                                    sealed_q <= 1'b0;
            else if (in_valid && core_in_ready && ctrl_q[2]) sealed_q <= 1'b1;
            if ((wstate == W_EXEC) && (wstate_nx == W_RESP))
                bresp_q <= w_err ? 2'b10 : 2'b00;
        end
    end

    always_comb begin
        rd_word = '0;
        rd_err  = 1'b0;
        case (rword)
            A_CTRL: rd_word = {29'b0, ctrl_q};
            A_STAT: rd_word = {29'b0, sealed_q, in_valid, done_q};
            A_IN, A_CMD: begin
            end
            default: begin
                rd_err = (rword >= OUT_END);
                for (int unsigned i = 0; i < N_OUT; i++)
                    if (rword == word_t'(i + 4))
                        rd_word = core_hash[(N_OUT-1-i)*32 +: 32];
            end
        endcase
    end

    always_comb begin
        rstate_nx = rstate;
        case (rstate)
            R_IDLE: if (rd_hs) rstate_nx = R_DATA;
            R_DATA: if (S_AXI_RREADY) rstate_nx = R_IDLE;
            default: rstate_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rstate    <= R_IDLE;
            arready_q <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            rstate    <= rstate_nx;
            arready_q <= (rstate == R_IDLE) && S_AXI_ARVALID && !arready_q;
            if (rd_hs) begin
                rdata_q <= rd_word;
                rresp_q <= rd_err ? 2'b10 : 2'b00;
            end
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = (wstate == W_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = (rstate == R_DATA);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign core_rst      = core_rst_q;
    assign core_in_valid = in_valid;
    assign core_in_data  = wdata_q;
    assign core_in_last  = ctrl_q[2];
    assign core_in_bytes = ctrl_q[1:0];
endmodule
